// File: rtl/arbiter_wrr_hs.sv
// arbiter_wrr_hs: fixed-priority, round-robin or weighted round-robin arbiter
// with req/rdy handshakes upstream and a registered gnt/rdy handshake downstream.
module arbiter_wrr_hs #(
   parameter int WIDTH_REQ    = 8,
   parameter int MODE         = 1,
   parameter int WIDTH_WEIGHT = 4
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [WIDTH_REQ-1:0]              req_i,
   output logic [WIDTH_REQ-1:0]              req_rdy_o,
   input  logic [WIDTH_REQ*WIDTH_WEIGHT-1:0] weight_i,
   output logic [WIDTH_REQ-1:0]              gnt_o,
   input  logic                              gnt_rdy_i
);
   localparam int PW = $clog2(WIDTH_REQ);
   typedef logic [PW-1:0] idx_t;

   logic [WIDTH_REQ-1:0]    gnt_q, gnt_d, cand, win_oh;
   idx_t                    ptr_q, ptr_d, owner_q, owner_d, win, nxt;
   logic [WIDTH_WEIGHT-1:0] credit_q, credit_d, wt, ew;
   logic                    busy, hs, bubble, take;

   // Circular scan from s upward; the lowest offset from s wins.
   function automatic idx_t pick(input logic [WIDTH_REQ-1:0] c, input idx_t s);
      int j;
      pick = s;
      for (int k = WIDTH_REQ - 1; k >= 0; k--) begin
         j = (int'(s) + k) % WIDTH_REQ;
         if (c[j]) pick = idx_t'(j);
      end
   endfunction

   assign busy   = |gnt_q;
   assign hs     = busy & gnt_rdy_i;
   assign bubble = (MODE == 2) && (credit_q != '0);
   assign cand   = busy ? (req_i & ~gnt_q) : req_i;
   assign win    = pick(cand, (MODE == 0) ? idx_t'(0) : ptr_q);
   assign win_oh = WIDTH_REQ'(1) << win;
   assign take   = busy ? (hs && !bubble && (|cand)) : (|req_i);
   assign wt     = weight_i[win*WIDTH_WEIGHT +: WIDTH_WEIGHT];
   assign ew     = (MODE == 2 && wt != '0) ? wt : WIDTH_WEIGHT'(1);
   assign nxt    = (win == idx_t'(WIDTH_REQ - 1)) ? idx_t'(0) : win + idx_t'(1);

   // A continuing owner spends credit; any other winner reloads from its weight.
   always_comb begin
      gnt_d    = gnt_q;
      owner_d  = owner_q;
      credit_d = credit_q;
      ptr_d    = ptr_q;
      if (!busy || hs) gnt_d = take ? win_oh : '0;
      if (take) begin
         if (win == owner_q && credit_q != '0) begin
            credit_d = credit_q - WIDTH_WEIGHT'(1);
         end else begin
            owner_d  = win;
            credit_d = ew - WIDTH_WEIGHT'(1);
         end
         ptr_d = (MODE == 1) ? nxt : (MODE == 2) ? ((credit_d != '0) ? win : nxt) : idx_t'(0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gnt_q    <= '0;
         ptr_q    <= '0;
         owner_q  <= '0;
         credit_q <= '0;
      end else begin
         gnt_q    <= gnt_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         credit_q <= credit_d;
      end
   end

   assign gnt_o     = gnt_q;
   assign req_rdy_o = gnt_q & {WIDTH_REQ{gnt_rdy_i}};
endmodule

// File: tb/tb_arbiter_wrr_hs.sv
// tb_arbiter_wrr_hs: directed scoreboard bench; one instance per arbitration mode,
// stimulus pushes the expected grant per cycle and a negedge monitor checks it.
module tb_arbiter_wrr_hs;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  req [3];
   logic        rdy [3];
   logic [31:0] wt [3];
   logic [7:0]  gnt [3];
   logic [7:0]  rr [3];
   int          total = 0;
   int          bad = 0;

   typedef struct {
      int         id;
      logic [7:0] g;
      logic [7:0] r;
   } exp_t;
   exp_t q[$];

   always #5 clk = ~clk;

   arbiter_wrr_hs #(.WIDTH_REQ(8), .MODE(0), .WIDTH_WEIGHT(4)) u_fp (
      .clk(clk), .reset_n(reset_n), .req_i(req[0]), .req_rdy_o(rr[0]),
      .weight_i(wt[0]), .gnt_o(gnt[0]), .gnt_rdy_i(rdy[0]));
   arbiter_wrr_hs #(.WIDTH_REQ(8), .MODE(1), .WIDTH_WEIGHT(4)) u_rr (
      .clk(clk), .reset_n(reset_n), .req_i(req[1]), .req_rdy_o(rr[1]),
      .weight_i(wt[1]), .gnt_o(gnt[1]), .gnt_rdy_i(rdy[1]));
   arbiter_wrr_hs #(.WIDTH_REQ(8), .MODE(2), .WIDTH_WEIGHT(4)) u_wrr (
      .clk(clk), .reset_n(reset_n), .req_i(req[2]), .req_rdy_o(rr[2]),
      .weight_i(wt[2]), .gnt_o(gnt[2]), .gnt_rdy_i(rdy[2]));

   // Monitor: every queued expectation is checked at the following falling edge.
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         total++;
         if (gnt[e.id] !== e.g) begin
            bad++;
            $display("FAIL gnt dut=%0d got=%h want=%h t=%0t", e.id, gnt[e.id], e.g, $time);
         end
         total++;
         if (rr[e.id] !== e.r) begin
            bad++;
            $display("FAIL req_rdy dut=%0d got=%h want=%h t=%0t", e.id, rr[e.id], e.r, $time);
         end
      end
   end

   // e is the grant expected after the edge just passed; r/g drive the next edge.
   task automatic step(input int id, input logic [7:0] r, input logic g, input logic [7:0] e);
      @(posedge clk);
      #1;
      req[id] = r;
      rdy[id] = g;
      q.push_back('{id, e, e & {8{g}}});
   endtask

   // Reset is asserted between edges, so a zero grant here proves the async clear.
   task automatic do_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) q.push_back('{i, 8'h00, 8'h00});
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         req[i] = '0;
         rdy[i] = 1'b0;
         wt[i]  = '0;
      end
      wt[2] = 32'h0000_0013;
      do_reset();
      // single request, stalled downstream then accepted
      step(1, 8'h04, 1'b0, 8'h00);
      step(1, 8'h04, 1'b0, 8'h04);
      step(1, 8'h04, 1'b0, 8'h04);
      step(1, 8'h04, 1'b1, 8'h04);
      step(1, 8'h00, 1'b0, 8'h00);
      step(1, 8'h00, 1'b0, 8'h00);
      // round robin, back-to-back across the wrap
      do_reset();
      step(1, 8'hFF, 1'b1, 8'h00);
      for (int i = 0; i < 9; i++) step(1, 8'hFF, 1'b1, 8'h01 << (i % 8));
      step(1, 8'h00, 1'b1, 8'h02);
      step(1, 8'h00, 1'b0, 8'h00);
      // fixed priority alternation
      do_reset();
      step(0, 8'h0A, 1'b1, 8'h00);
      step(0, 8'h0A, 1'b1, 8'h02);
      step(0, 8'h0A, 1'b1, 8'h08);
      step(0, 8'h0A, 1'b1, 8'h02);
      step(0, 8'h00, 1'b1, 8'h08);
      step(0, 8'h00, 1'b0, 8'h00);
      // weighted: w0=3, w1=1, w2=0
      do_reset();
      step(2, 8'h07, 1'b1, 8'h00);
      step(2, 8'h07, 1'b1, 8'h01);
      step(2, 8'h07, 1'b1, 8'h00);
      step(2, 8'h07, 1'b1, 8'h01);
      step(2, 8'h07, 1'b1, 8'h00);
      step(2, 8'h07, 1'b1, 8'h01);
      step(2, 8'h07, 1'b1, 8'h02);
      step(2, 8'h07, 1'b1, 8'h04);
      step(2, 8'h07, 1'b1, 8'h01);
      step(2, 8'h00, 1'b0, 8'h00);
      step(2, 8'h00, 1'b0, 8'h00);
      // forfeit: w0=4, w1=2; requester 0 leaves with credit, requester 1 reloads to 1
      wt[2] = 32'h0000_0024;
      do_reset();
      step(2, 8'h03, 1'b1, 8'h00);
      step(2, 8'h03, 1'b1, 8'h01);
      step(2, 8'h02, 1'b1, 8'h00);
      step(2, 8'h02, 1'b1, 8'h02);
      step(2, 8'h02, 1'b1, 8'h00);
      step(2, 8'h02, 1'b1, 8'h02);
      step(2, 8'h00, 1'b0, 8'h00);
      // reset mid-grant, then pointer restart
      step(1, 8'h20, 1'b1, 8'h00);
      step(1, 8'h20, 1'b1, 8'h20);
      step(1, 8'h10, 1'b0, 8'h00);
      step(1, 8'h10, 1'b0, 8'h10);
      do_reset();
      step(1, 8'h10, 1'b1, 8'h10);
      step(1, 8'h00, 1'b0, 8'h00);
      do_reset();
      step(1, 8'h30, 1'b0, 8'h00);
      step(1, 8'h30, 1'b1, 8'h10);
      step(1, 8'h00, 1'b1, 8'h20);
      step(1, 8'h00, 1'b0, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain left=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
